// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin owner selection for the shared frame-buffer SRAM,
// with a hold limit and one turnaround cycle between owners.
module sram_arbiter #(
  parameter int NREQ     = 4,
  parameter int ID_W     = 2,
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic            clk,
  input  logic            r_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] rel,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;
  state_t state, nstate;
  logic [ID_W-1:0] last, nlast, win, nid;
  logic [CNT_W-1:0] hold, nhold;
  logic [NREQ-1:0] ngnt;
  logic nto, own_req, own_rel, hit;
  // Requesters above the last owner win over those at or below it; lowest index first.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (i <= int'(last) && req[i]) win = ID_W'(i);
    for (int i = NREQ - 1; i >= 0; i--) if (i > int'(last) && req[i]) win = ID_W'(i);
  end
  assign own_req = |(req & gnt);
  assign own_rel = |(rel & gnt);
  assign hit     = hold == CNT_W'(HOLD_MAX);
  always_comb begin
    nstate = state;
    ngnt   = gnt;
    nid    = gnt_id;
    nlast  = last;
    nhold  = hold;
    nto    = 1'b0;
    case (state)
      GRANT: begin
        if (own_rel || !own_req || hit) begin
          nstate = RECOVER;
          ngnt   = '0;
          nid    = '0;
          nto    = hit && own_req && !own_rel;
        end else begin
          nhold = hold + CNT_W'(1);
        end
      end
      default: begin
        nstate = (|req) ? GRANT : IDLE;
        if (|req) begin
          ngnt  = NREQ'(1) << win;
          nid   = win;
          nlast = win;
          nhold = CNT_W'(1);
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      last    <= ID_W'(NREQ - 1);
      hold    <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= nstate;
      gnt     <= ngnt;
      gnt_id  <= nid;
      last    <= nlast;
      hold    <= nhold;
      busy    <= nstate != IDLE;
      timeout <= nto;
    end
  end
endmodule
